// File: rtl/reg_file_8x16.sv
// ---------------------------------------------------------------------------
// reg_file_8x16
//   Eight-entry register file with one write port, two registered read ports
//   and a sequential clear engine that zeroes one register per clock.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     we       in   write enable
//     waddr    in   [2:0] write register select
//     wdata    in   [DATA_W-1:0] write data
//     raddr_a  in   [2:0] read port A select
//     raddr_b  in   [2:0] read port B select
//     clr_req  in   start a clear of r0..r7 (ignored while a clear runs)
//     rdata_a  out  [DATA_W-1:0] read data A, one cycle after address sample
//     rdata_b  out  [DATA_W-1:0] read data B, one cycle after address sample
//     busy     out  high while the clear sequence runs
//     wr_drop  out  one-cycle pulse after a discarded write
//
//   Build option
//     REG_FILE_BYPASS_EN : when defined, an accepted write is forwarded to a
//     read port sampling the same address on the same edge. When undefined
//     the read returns the pre-write contents.
// ---------------------------------------------------------------------------
module reg_file_8x16 #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic [2:0]        cnt_next;

  logic [DATA_W-1:0] regs [NREGS];

  logic              wr_accept;
  logic              wr_discard;
  logic              clear_en;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The counter wraps 7 -> 0 on the same edge that returns
  // to IDLE, so every register is zeroed exactly once per clear.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / control decode. busy comes straight from the state flop, so it
  // is glitch-free and registered.
  // -------------------------------------------------------------------------
  always_comb begin
    busy       = (state == CLEAR);
    clear_en   = (state == CLEAR);
    wr_accept  = we && (state == IDLE) && !clr_req;
    wr_discard = we && ((state == CLEAR) || clr_req);
  end

  // -------------------------------------------------------------------------
  // Register array
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clear_en) begin
      regs[cnt] <= '0;
    end else if (wr_accept) begin
      regs[waddr] <= wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Registered read ports (optionally forwarding an accepted write)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
`ifdef REG_FILE_BYPASS_EN
      rdata_a <= (wr_accept && (waddr == raddr_a)) ? wdata : regs[raddr_a];
      rdata_b <= (wr_accept && (waddr == raddr_b)) ? wdata : regs[raddr_b];
`else
      rdata_a <= regs[raddr_a];
      rdata_b <= regs[raddr_b];
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Discarded-write indicator: one pulse on the cycle after the drop
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_discard;
    end
  end

endmodule
